cpu_io_port: RTL
================

# cpu_io_port

Byte-wide I/O port that sits between the multi-cycle accumulator processor and an external host. On the input side it buffers host bytes and presents them on the processor's `IN` bus, popping one per processor read strobe. On the output side it captures the processor's `OUT` bus on a write strobe and drains the captured bytes to the host over a valid/ready handshake.

## Interface
Parameters:
- `DEPTH`, 4: entries per FIFO (RX and TX); must be a power of two, ≥2.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-low reset.
- `host_in_data`  in  8  byte from host.
- `host_in_valid`  in  1  host byte valid.
- `host_in_ready`  out  1  RX FIFO can accept (`rx_count < DEPTH`).
- `IN`  out  8  byte presented to processor: RX head, 8'd0 when RX empty.
- `in_avail`  out  1  RX non-empty.
- `in_rd`  in  1  processor read strobe, one-cycle pulse; pops RX head.
- `OUT`  in  8  processor output byte.
- `out_wr`  in  1  processor write strobe, one-cycle pulse; pushes `OUT` into TX.
- `out_full`  out  1  TX FIFO full.
- `host_out_data`  out  8  TX head, 8'd0 when TX empty.
- `host_out_valid`  out  1  TX non-empty.
- `host_out_ready`  in  1  host accepts TX head.
- `err_clr`  in  1  clears sticky error flags.
- `in_udf`  out  1  sticky: `in_rd` while RX empty.
- `out_ovf`  out  1  sticky: `out_wr` while TX full (byte dropped).

## Operation
- Two independent circular FIFOs, each: `DEPTH`×8 storage, read/write pointers of log2(DEPTH) bits wrapping modulo DEPTH, occupancy counter of log2(DEPTH)+1 bits (0..DEPTH).
- RX push: `host_in_valid && host_in_ready` at an edge writes `host_in_data` at write pointer, advances it.
- RX pop: `in_rd && in_avail` advances read pointer. `in_rd` with RX empty: no pointer change, `in_udf` set.
- TX push: `out_wr && !out_full` writes `OUT`. `out_wr && out_full`: byte discarded, no state change except `out_ovf` set — even if host pops that same cycle (full judged on pre-edge count).
- TX pop: `host_out_valid && host_out_ready`.
- Simultaneous push and pop on one FIFO: both take effect, count unchanged. RX push when full is impossible (ready low), so a full RX with a same-cycle pop still refuses the host byte that cycle.
- `host_in_ready`, `in_avail`, `out_full`, `host_out_valid`, `IN`, `host_out_data` are combinational from registered pointers/counters/storage only; no combinational path from any input to any output.
- Error flags: set on event, held until `err_clr`; `err_clr` and a new event in the same cycle → flag stays set.
- Storage contents are not reset; outputs mask them to 8'd0 while the FIFO is empty.

## Timing
- Reset (`reset`=0 at an edge): both FIFOs empty, pointers 0, counts 0, flags 0. After reset: `IN`=0, `in_avail`=0, `host_in_ready`=1, `out_full`=0, `host_out_data`=0, `host_out_valid`=0, `in_udf`=0, `out_ovf`=0.
- Reset asserted mid-transfer discards all buffered bytes on that edge; strobes in that cycle are ignored.
- Host→processor latency: byte accepted at edge N is on `IN` with `in_avail`=1 in the cycle after edge N.
- Processor→host latency: `out_wr` at edge N gives `host_out_valid`=1, `host_out_data`=byte after edge N.
- Pop at edge N: next entry (or 8'd0/empty) visible immediately after edge N.
- Throughput: one push and one pop per FIFO per cycle.

## Test plan
- Reset then idle: hold `reset`=0 two cycles, release -> all outputs at reset values; `host_in_ready`=1.
- RX ordering/wrap: host pushes 8'd8, 8'd3, 8'd5, 8'd9 back-to-back -> `host_in_ready`=0 after 4th; `IN`=8 then 3, 5, 9 on successive `in_rd`; push 6 more with interleaved reads across pointer wrap -> order preserved, `IN`=0 when drained.
- TX overflow: 5 `out_wr` pulses of 8'h11..8'h15 with `host_out_ready`=0 -> `out_full`=1 after 4th, `out_ovf`=1 after 5th; drain yields 11,12,13,14 only.
- Simultaneous: TX holding 2 bytes, `out_wr`(8'hA5) and host pop same cycle -> count stays 2, order correct; RX full with `in_rd` and `host_in_valid` same cycle -> host byte refused that cycle, accepted next.
- Errors: `in_rd` on empty RX -> `in_udf`=1, pointers unchanged; `err_clr` same cycle as another empty `in_rd` -> stays 1; lone `err_clr` -> 0.
- Reset mid-operation: RX 3 bytes, TX 2 bytes, assert `reset`=0 one edge -> both empty, `IN`=0, `host_out_valid`=0, flags 0.

Source files
------------

// File: rtl/cpu_io_port.sv
// cpu_io_port
// Byte-wide I/O port between the accumulator processor and an external host.
//   RX path: host bytes -> RX FIFO -> processor IN bus (popped by in_rd).
//   TX path: processor OUT bus (pushed by out_wr) -> TX FIFO -> host.
// Ports:
//   clk, reset (synchronous, active-low)
//   host_in_data/host_in_valid/host_in_ready   : host -> RX FIFO handshake
//   IN/in_avail/in_rd                          : RX head to processor, read strobe
//   OUT/out_wr/out_full                        : processor write strobe into TX FIFO
//   host_out_data/host_out_valid/host_out_ready: TX FIFO -> host handshake
//   err_clr/in_udf/out_ovf                     : sticky error flags and their clear
// Handshake rule for both host channels: a byte moves at a rising edge exactly
// when valid and ready are both high there; valid/ready never depend on each
// other combinationally, and every output is a function of registered state.
module cpu_io_port #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] host_in_data,
  input  logic       host_in_valid,
  output logic       host_in_ready,
  output logic [7:0] IN,
  output logic       in_avail,
  input  logic       in_rd,
  input  logic [7:0] OUT,
  input  logic       out_wr,
  output logic       out_full,
  output logic [7:0] host_out_data,
  output logic       host_out_valid,
  input  logic       host_out_ready,
  input  logic       err_clr,
  output logic       in_udf,
  output logic       out_ovf
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  // Storage is deliberately not reset; outputs mask it while empty.
  logic [7:0]    rx_mem_q [DEPTH];
  logic [7:0]    tx_mem_q [DEPTH];

  logic [AW-1:0] rx_wr_ptr_q, rx_wr_ptr_d, rx_rd_ptr_q, rx_rd_ptr_d;
  logic [AW-1:0] tx_wr_ptr_q, tx_wr_ptr_d, tx_rd_ptr_q, tx_rd_ptr_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d;
  logic          in_udf_q, in_udf_d, out_ovf_q, out_ovf_d;

  logic rx_empty, rx_full, tx_empty, tx_full;
  logic rx_push, rx_pop, tx_push, tx_pop;

  // Fullness/emptiness come from the pre-edge counts only, so a full FIFO
  // refuses a push even when a pop happens in the same cycle.
  assign rx_empty = (rx_cnt_q == '0);
  assign rx_full  = (rx_cnt_q == FULL_CNT);
  assign tx_empty = (tx_cnt_q == '0);
  assign tx_full  = (tx_cnt_q == FULL_CNT);

  assign rx_push = host_in_valid && !rx_full;
  assign rx_pop  = in_rd && !rx_empty;
  assign tx_push = out_wr && !tx_full;
  assign tx_pop  = host_out_ready && !tx_empty;

  always_comb begin
    rx_wr_ptr_d = rx_wr_ptr_q;
    rx_rd_ptr_d = rx_rd_ptr_q;
    rx_cnt_d    = rx_cnt_q;
    tx_wr_ptr_d = tx_wr_ptr_q;
    tx_rd_ptr_d = tx_rd_ptr_q;
    tx_cnt_d    = tx_cnt_q;

    // Pointers wrap naturally because DEPTH is a power of two.
    if (rx_push) rx_wr_ptr_d = rx_wr_ptr_q + AW'(1);
    if (rx_pop)  rx_rd_ptr_d = rx_rd_ptr_q + AW'(1);
    if (tx_push) tx_wr_ptr_d = tx_wr_ptr_q + AW'(1);
    if (tx_pop)  tx_rd_ptr_d = tx_rd_ptr_q + AW'(1);

    case ({rx_push, rx_pop})
      2'b10:   rx_cnt_d = rx_cnt_q + CW'(1);
      2'b01:   rx_cnt_d = rx_cnt_q - CW'(1);
      default: rx_cnt_d = rx_cnt_q;
    endcase

    case ({tx_push, tx_pop})
      2'b10:   tx_cnt_d = tx_cnt_q + CW'(1);
      2'b01:   tx_cnt_d = tx_cnt_q - CW'(1);
      default: tx_cnt_d = tx_cnt_q;
    endcase

    // A new event wins over a same-cycle clear.
    in_udf_d  = (in_udf_q && !err_clr) || (in_rd && rx_empty);
    out_ovf_d = (out_ovf_q && !err_clr) || (out_wr && tx_full);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_wr_ptr_q <= '0;
      rx_rd_ptr_q <= '0;
      rx_cnt_q    <= '0;
      tx_wr_ptr_q <= '0;
      tx_rd_ptr_q <= '0;
      tx_cnt_q    <= '0;
      in_udf_q    <= 1'b0;
      out_ovf_q   <= 1'b0;
    end else begin
      rx_wr_ptr_q <= rx_wr_ptr_d;
      rx_rd_ptr_q <= rx_rd_ptr_d;
      rx_cnt_q    <= rx_cnt_d;
      tx_wr_ptr_q <= tx_wr_ptr_d;
      tx_rd_ptr_q <= tx_rd_ptr_d;
      tx_cnt_q    <= tx_cnt_d;
      in_udf_q    <= in_udf_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset && rx_push) rx_mem_q[rx_wr_ptr_q] <= host_in_data;
    if (reset && tx_push) tx_mem_q[tx_wr_ptr_q] <= OUT;
  end

  assign host_in_ready  = !rx_full;
  assign in_avail       = !rx_empty;
  assign IN             = rx_empty ? 8'd0 : rx_mem_q[rx_rd_ptr_q];
  assign out_full       = tx_full;
  assign host_out_valid = !tx_empty;
  assign host_out_data  = tx_empty ? 8'd0 : tx_mem_q[tx_rd_ptr_q];
  assign in_udf         = in_udf_q;
  assign out_ovf        = out_ovf_q;

endmodule
